// File: rtl/mac_operand_feeder_if.sv
// Operand-feeder bus: producer push side, run control and MAC-facing operand stream.
// Width parameters must match those of the attached mac_operand_feeder.
interface mac_operand_feeder_if #(
  parameter int P_NBITS = 32,
  parameter int P_CNT_W = 8
);
  logic               in_val;
  logic               in_rdy;
  logic [P_NBITS-1:0] in_a;
  logic [P_NBITS-1:0] in_b;
  logic               start;
  logic [P_CNT_W-1:0] len;
  logic               out_val;
  logic               out_rdy;
  logic [P_NBITS-1:0] a;
  logic [P_NBITS-1:0] b;
  logic               busy;
  logic               done;
  logic [P_CNT_W-1:0] issued_cnt;

  modport master (
    output in_val, in_a, in_b, start, len, out_rdy,
    input  in_rdy, out_val, a, b, busy, done, issued_cnt
  );

  modport slave (
    input  in_val, in_a, in_b, start, len, out_rdy,
    output in_rdy, out_val, a, b, busy, done, issued_cnt
  );
endinterface

// File: rtl/mac_operand_feeder.sv
// Queues (a,b) operand pairs and issues a counted run of them to the MAC pipeline
// through a registered valid/ready output stage, ending with a one-cycle done pulse.
module mac_operand_feeder #(
  parameter int P_NBITS = 32,
  parameter int P_DEPTH = 4,
  parameter int P_CNT_W = 8
) (
  input logic                  clk,
  input logic                  nreset,
  mac_operand_feeder_if.slave  bus
);
  localparam int AW = $clog2(P_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state;
  logic [P_NBITS-1:0] mem_a [P_DEPTH];
  logic [P_NBITS-1:0] mem_b [P_DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [P_NBITS-1:0] a_q;
  logic [P_NBITS-1:0] b_q;
  logic               out_val_q;
  logic               busy_q;
  logic               done_q;
  logic [P_CNT_W-1:0] issued_q;
  logic [P_CNT_W-1:0] remaining;

  logic full;
  logic empty;
  logic push;
  logic xfer;
  logic load;

  // Extra wrap bit on the pointers separates full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = bus.in_val && !full;
  assign xfer  = out_val_q && bus.out_rdy;
  assign load  = (state == S_RUN) && (remaining != '0) && !empty
              && (!out_val_q || bus.out_rdy);

  // NOTE: the pair storage has no reset; only the pointers decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr[AW-1:0]] <= bus.in_a;
      mem_b[wr_ptr[AW-1:0]] <= bus.in_b;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // NOTE: every register below updates with <= so all branches see pre-edge values.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= S_IDLE;
      rd_ptr    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      out_val_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      issued_q  <= '0;
      remaining <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            remaining <= bus.len;
            issued_q  <= '0;
            busy_q    <= 1'b1;
            if (bus.len != '0) begin
              state <= S_RUN;
            end else begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (load) begin
            a_q       <= mem_a[rd_ptr[AW-1:0]];
            b_q       <= mem_b[rd_ptr[AW-1:0]];
            out_val_q <= 1'b1;
            rd_ptr    <= rd_ptr + 1'b1;
            remaining <= remaining - 1'b1;
          end else if (xfer) begin
            out_val_q <= 1'b0;
          end
          if (xfer) begin
            issued_q <= issued_q + 1'b1;
            // remaining==0 here means the register held the last pair of the run.
            if (remaining == '0) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_rdy     = !full;
  assign bus.out_val    = out_val_q;
  assign bus.a          = a_q;
  assign bus.b          = b_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.issued_cnt = issued_q;
endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder: reset, runs, backpressure, full/wrap,
// starvation, zero length, ignored start, leftovers and mid-run reset.
module tb_mac_operand_feeder;
  localparam int P_NBITS = 32;
  localparam int P_DEPTH = 4;
  localparam int P_CNT_W = 8;

  logic clk;
  logic nreset;
  int   n_cmp = 0;
  int   n_err = 0;

  mac_operand_feeder_if #(.P_NBITS(P_NBITS), .P_CNT_W(P_CNT_W)) bus ();

  mac_operand_feeder #(.P_NBITS(P_NBITS), .P_DEPTH(P_DEPTH), .P_CNT_W(P_CNT_W)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pa, input logic [31:0] pb);
    bus.in_val = 1'b1;
    bus.in_a   = pa;
    bus.in_b   = pb;
    tick();
    bus.in_val = 1'b0;
  endtask

  task automatic start_run(input logic [7:0] l);
    bus.start = 1'b1;
    bus.len   = l;
    tick();
    bus.start = 1'b0;
  endtask

  logic [31:0] exp_a [4];
  logic [31:0] exp_b [4];
  int          p;

  initial begin
    nreset      = 1'b0;
    bus.in_val  = 1'b0;
    bus.in_a    = '0;
    bus.in_b    = '0;
    bus.start   = 1'b0;
    bus.len     = '0;
    bus.out_rdy = 1'b0;
    repeat (3) tick();
    nreset = 1'b1;
    tick();

    // Reset state
    check("rst_a", bus.a, 0);
    check("rst_b", bus.b, 0);
    check("rst_out_val", bus.out_val, 0);
    check("rst_in_rdy", bus.in_rdy, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_issued", bus.issued_cnt, 0);

    // Basic run of four pairs, no backpressure
    exp_a = '{1, 3, 10, 2};
    exp_b = '{2, 10, 1, 12};
    for (int i = 0; i < 4; i++) push(exp_a[i], exp_b[i]);
    check("basic_full", bus.in_rdy, 0);
    bus.out_rdy = 1'b1;
    start_run(4);
    check("basic_busy", bus.busy, 1);
    check("basic_no_val_yet", bus.out_val, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("basic_a%0d", i), bus.a, exp_a[i]);
      check($sformatf("basic_b%0d", i), bus.b, exp_b[i]);
      check($sformatf("basic_val%0d", i), bus.out_val, 1);
      check($sformatf("basic_done%0d", i), bus.done, 0);
    end
    tick();
    check("basic_done", bus.done, 1);
    check("basic_val_off", bus.out_val, 0);
    check("basic_issued", bus.issued_cnt, 4);
    tick();
    check("basic_done_clr", bus.done, 0);
    check("basic_idle", bus.busy, 0);
    check("basic_issued_hold", bus.issued_cnt, 4);

    // Backpressure: hold the first pair for three cycles
    push(5, 13);
    push(7, 9);
    bus.out_rdy = 1'b0;
    start_run(2);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp_hold_a%0d", i), bus.a, 5);
      check($sformatf("bp_hold_b%0d", i), bus.b, 13);
      check($sformatf("bp_hold_val%0d", i), bus.out_val, 1);
      check($sformatf("bp_hold_iss%0d", i), bus.issued_cnt, 0);
    end
    bus.out_rdy = 1'b1;
    tick();
    check("bp_next_a", bus.a, 7);
    check("bp_next_b", bus.b, 9);
    check("bp_issued1", bus.issued_cnt, 1);
    check("bp_no_done", bus.done, 0);
    tick();
    check("bp_done", bus.done, 1);
    check("bp_issued2", bus.issued_cnt, 2);
    tick();

    // Full FIFO, rejected pushes and pointer wrap over 10 pairs
    for (int i = 0; i < 4; i++) push(10 + i, 110 + i);
    check("wrap_full", bus.in_rdy, 0);
    push(32'hdead, 32'hbeef);
    check("wrap_still_full", bus.in_rdy, 0);
    start_run(10);
    p = 14;
    for (int i = 0; i < 10; i++) begin
      bus.in_val = (p <= 19);
      bus.in_a   = p;
      bus.in_b   = 100 + p;
      check($sformatf("wrap_rdy%0d", i), bus.in_rdy, (i != 0));
      tick();
      if (i != 0 && p <= 19) p++;
      check($sformatf("wrap_a%0d", i), bus.a, 10 + i);
      check($sformatf("wrap_b%0d", i), bus.b, 110 + i);
    end
    bus.in_val = 1'b0;
    tick();
    check("wrap_done", bus.done, 1);
    check("wrap_issued", bus.issued_cnt, 10);
    check("wrap_empty", bus.out_val, 0);
    tick();

    // Starved run, with a start pulse during RUN that must be ignored
    push(20, 120);
    start_run(3);
    tick();
    check("starve_a0", bus.a, 20);
    tick();
    check("starve_val_drop", bus.out_val, 0);
    check("starve_busy", bus.busy, 1);
    check("starve_issued1", bus.issued_cnt, 1);
    tick();
    check("starve_wait", bus.out_val, 0);
    push(21, 121);
    check("starve_no_bypass", bus.out_val, 0);
    bus.in_val = 1'b1;
    bus.in_a   = 22;
    bus.in_b   = 122;
    bus.start  = 1'b1;
    bus.len    = 7;
    tick();
    bus.in_val = 1'b0;
    bus.start  = 1'b0;
    check("starve_a1", bus.a, 21);
    check("starve_b1", bus.b, 121);
    tick();
    check("starve_a2", bus.a, 22);
    check("starve_issued2", bus.issued_cnt, 2);
    tick();
    check("starve_done", bus.done, 1);
    check("starve_issued3", bus.issued_cnt, 3);
    tick();
    check("starve_idle", bus.busy, 0);

    // Zero-length run
    start_run(0);
    check("len0_done", bus.done, 1);
    check("len0_busy", bus.busy, 1);
    check("len0_issued", bus.issued_cnt, 0);
    tick();
    check("len0_done_clr", bus.done, 0);
    check("len0_idle", bus.busy, 0);

    // Leftover pairs carried into the next run
    for (int i = 0; i < 4; i++) push(30 + i, 130 + i);
    start_run(2);
    tick();
    check("left_a0", bus.a, 30);
    bus.in_val = 1'b1;
    bus.in_a   = 34;
    bus.in_b   = 134;
    tick();
    bus.in_val = 1'b0;
    check("left_a1", bus.a, 31);
    tick();
    check("left_done1", bus.done, 1);
    check("left_issued1", bus.issued_cnt, 2);
    tick();
    start_run(3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("left2_a%0d", i), bus.a, 32 + i);
      check($sformatf("left2_b%0d", i), bus.b, 132 + i);
    end
    tick();
    check("left_done2", bus.done, 1);
    check("left_issued2", bus.issued_cnt, 3);
    tick();

    // Reset in the middle of a run with three pairs still queued
    bus.out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) push(40 + i, 140 + i);
    start_run(4);
    tick();
    check("mid_loaded", bus.a, 40);
    #2;
    nreset = 1'b0;
    #1;
    check("mid_rst_val", bus.out_val, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_rdy", bus.in_rdy, 1);
    check("mid_rst_a", bus.a, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("mid_rst_done%0d", i), bus.done, 0);
    end
    nreset = 1'b1;
    tick();
    check("mid_post_done", bus.done, 0);
    check("mid_post_busy", bus.busy, 0);
    bus.out_rdy = 1'b1;
    start_run(1);
    tick();
    tick();
    check("mid_flushed", bus.out_val, 0);
    check("mid_flushed_busy", bus.busy, 1);
    push(50, 150);
    tick();
    check("mid_new_a", bus.a, 50);
    check("mid_new_val", bus.out_val, 1);
    tick();
    check("mid_new_done", bus.done, 1);
    check("mid_new_issued", bus.issued_cnt, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
